// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing a two-digit seven-segment display among NREQ BCD sources.
// Optional macro HEX_ARB_DP_SRC_EN: decimal points show the low two bits of the grant index.

module hex_arb_seg_dec (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // Active-low g..a; nibbles above 9 fall back to the "0" pattern.
  always_comb begin
    case (nib_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = 7'h40;
    endcase
  end
endmodule

module hex_display_arbiter #(
  parameter int NREQ  = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] bcd_in_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  output logic [7:0]        hex0_o,
  output logic [7:0]        hex1_o
);
  localparam int          CW      = $clog2(DWELL+1);
  localparam logic [2:0]  PTR_RST = 3'(NREQ-1);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First requester strictly after base, wrapping, with base itself checked last.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [2:0] base);
    pick_t p;
    int    j;
    p = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(base) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        p.found = 1'b1;
        p.idx   = 3'(j);
      end
    end
    return p;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++)
      if (idx == 3'(i)) oh[i] = 1'b1;
    return oh;
  endfunction

  state_t          state_q;
  logic [2:0]      g_q;        // current grant and round-robin pointer in one
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic [7:0]      hex0_q, hex1_q;

  pick_t           pk;
  logic            cur_req, rel, arb;
  logic [2:0]      g_d;
  logic [7:0]      bcd_sel;
  logic [1:0][6:0] seg_d;
  logic [1:0]      dp_d;

  always_comb begin
    pk      = rr_pick(req_i, g_q);
    cur_req = |(req_i & gnt_q);
    rel     = (state_q == HOLD) && ((cnt_q == '0) || !cur_req);
    arb     = (state_q == IDLE) || rel;
    g_d     = (arb && pk.found) ? pk.idx : g_q;
    bcd_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (g_d == 3'(i)) bcd_sel = bcd_in_i[8*i +: 8];
`ifdef HEX_ARB_DP_SRC_EN
    dp_d = ~g_d[1:0];
`else
    dp_d = 2'b11;
`endif
  end

  // Index 1 decodes the tens nibble, index 0 the ones nibble.
  hex_arb_seg_dec u_dec [1:0] (
    .nib_i (bcd_sel),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= PTR_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hex0_q  <= 8'hFF;
      hex1_q  <= 8'hFF;
    end else begin
      case (state_q)
        IDLE: begin
          if (pk.found) begin
            state_q <= HOLD;
            g_q     <= pk.idx;
            cnt_q   <= CW'(DWELL-1);
            gnt_q   <= onehot(pk.idx);
            busy_q  <= 1'b1;
            hex0_q  <= {dp_d[0], seg_d[0]};
            hex1_q  <= {dp_d[1], seg_d[1]};
          end
        end
        HOLD: begin
          if (rel && !pk.found) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            hex0_q  <= 8'hFF;
            hex1_q  <= 8'hFF;
          end else begin
            if (rel) begin
              g_q   <= pk.idx;
              cnt_q <= CW'(DWELL-1);
              gnt_q <= onehot(pk.idx);
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
            hex0_q <= {dp_d[0], seg_d[0]};
            hex1_q <= {dp_d[1], seg_d[1]};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;
  assign hex0_o = hex0_q;
  assign hex1_o = hex1_q;
endmodule
